// File: rtl/pipeline_sequencer.sv
// Run-control / hazard sequencer for the 5-stage pipeline: run, step, load-use stall, branch flush, drain-to-halt.
// Latency: segment controls are combinational from registered state; state/step_done/stall_count update one cycle later.
// Backpressure: none; a load-use hazard freezes PC and IF/ID and injects an ID/EX bubble.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dbg_run,
    input  logic        dbg_step,
    input  logic        dbg_halt,
    input  logic        id_halt_instr,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_m_mem_read,
    input  logic        id_branch_taken,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_en,
    output logic [2:0]  state,
    output logic        halted,
    output logic        step_done,
    output logic [15:0] stall_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] drain_cnt;
    logic          active;
    logic          stop;
    logic          load_use;

    assign active   = (state_q == S_RUN) || (state_q == S_STEP);
    assign stop     = active && (dbg_halt || id_halt_instr);
    assign load_use = ex_m_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (dbg_halt)      state_d = S_DRAIN;
                else if (dbg_step) state_d = S_STEP;
                else if (dbg_run)  state_d = S_RUN;
                else               state_d = S_IDLE;
            end
            S_RUN:    state_d = stop ? S_DRAIN : S_RUN;
            S_STEP:   state_d = stop ? S_DRAIN : S_IDLE;
            // A counter of 0 here can only come from a corrupted state; treat it as expired.
            S_DRAIN:  state_d = (drain_cnt <= CW'(1)) ? S_HALTED : S_DRAIN;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_en      = 1'b0;
        case (state_q)
            S_RUN, S_STEP: begin
                // Halt wins over load-use, which wins over branch (branch operands not yet valid).
                if (stop || load_use) begin
                    id_ex_bubble = 1'b1;
                    pipe_en      = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    pipe_en     = 1'b1;
                    if_id_flush = id_branch_taken;
                end
            end
            S_DRAIN: begin
                id_ex_bubble = 1'b1;
                pipe_en      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drain_cnt   <= '0;
            step_done   <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            if (state_q != S_DRAIN && state_d == S_DRAIN) begin
                drain_cnt <= CW'(DRAIN_CYCLES);
            end else if (state_q == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - CW'(1);
            end
            step_done <= (state_q == S_STEP) && !stop;
            if (active && !stop && load_use && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign state  = state_q;
    assign halted = (state_q == S_HALTED);
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed-vector bench for pipeline_sequencer with hand-computed expectations.
module tb_pipeline_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_run, dbg_step, dbg_halt, id_halt_instr;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_m_mem_read, id_branch_taken;
    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en;
    logic [2:0]  state;
    logic        halted, step_done;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    pipeline_sequencer #(.DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_halt(dbg_halt),
        .id_halt_instr(id_halt_instr), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rt(ex_rt), .ex_m_mem_read(ex_m_mem_read), .id_branch_taken(id_branch_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_en(pipe_en), .state(state),
        .halted(halted), .step_done(step_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then compare the five segment controls.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        #1;
        chk_vec(tag, {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}, {27'd0, exp});
    endtask

    task automatic clear_in();
        dbg_run = 0; dbg_step = 0; dbg_halt = 0; id_halt_instr = 0;
        id_rs = 0; id_rt = 0; ex_rt = 0; ex_m_mem_read = 0; id_branch_taken = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    initial begin
        clear_in();
        // Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
        reset = 0;
        tick();
        tick();
        chk_vec("rst_state", state, 0);
        chk_ctl("rst_ctl", 5'b00000);
        chk_vec("rst_misc", {halted, step_done, stall_count}, 0);
        reset = 1;

        // Single step
        dbg_step = 1; tick(); dbg_step = 0;
        chk_vec("step_state", state, 2);
        chk_ctl("step_ctl", 5'b11001);
        chk_vec("step_done_early", step_done, 0);
        tick();
        chk_vec("step_back_idle", state, 0);
        chk_vec("step_done_pulse", step_done, 1);
        chk_ctl("idle_ctl", 5'b00000);
        tick();
        chk_vec("step_done_once", step_done, 0);

        // Run + load-use
        dbg_run = 1; tick(); dbg_run = 0;
        chk_vec("run_state", state, 1);
        chk_ctl("run_ctl", 5'b11001);
        ex_m_mem_read = 1; ex_rt = 5; id_rs = 5;
        chk_ctl("lu_ctl", 5'b00011);
        chk_vec("lu_cnt_before", stall_count, 0);
        tick();
        chk_vec("lu_cnt_after", stall_count, 1);
        ex_rt = 0; id_rs = 0;
        chk_ctl("lu_r0_nostall", 5'b11001);
        tick();
        chk_vec("lu_r0_cnt", stall_count, 1);

        // Branch, then branch + load-use
        ex_m_mem_read = 0; id_branch_taken = 1;
        chk_ctl("br_flush", 5'b11101);
        ex_m_mem_read = 1; ex_rt = 7; id_rt = 7;
        chk_ctl("br_lu_stall", 5'b00011);
        tick();
        chk_vec("br_lu_cnt", stall_count, 2);

        // Halt instruction beats the pending load-use; no stall counted
        id_branch_taken = 0; id_halt_instr = 1;
        chk_ctl("stop_ctl", 5'b00011);
        tick();
        clear_in();
        chk_vec("stop_nocount", stall_count, 2);
        for (int i = 0; i < 4; i++) begin
            chk_vec($sformatf("drain_state_%0d", i), state, 3);
            chk_ctl($sformatf("drain_ctl_%0d", i), 5'b00011);
            chk_vec($sformatf("drain_halted_%0d", i), halted, 0);
            tick();
        end
        chk_vec("halted_state", state, 4);
        chk_vec("halted_flag", halted, 1);
        chk_ctl("halted_ctl", 5'b00000);
        dbg_run = 1; dbg_step = 1; tick(); clear_in(); tick();
        chk_vec("halted_sticky", state, 4);

        // Coincident pulses in IDLE, then reset mid-drain
        do_reset();
        dbg_halt = 1; dbg_step = 1; dbg_run = 1; tick(); clear_in();
        chk_vec("prio_drain", state, 3);
        tick();
        reset = 0; tick(); reset = 1;
        chk_vec("rst_drain_state", state, 0);
        chk_ctl("rst_drain_ctl", 5'b00000);
        chk_vec("rst_drain_misc", {halted, step_done}, 0);

        // Step interrupted by halt: drains, no step_done
        dbg_step = 1; tick(); dbg_step = 0;
        id_halt_instr = 1;
        chk_ctl("step_stop_ctl", 5'b00011);
        tick(); clear_in();
        chk_vec("step_stop_state", state, 3);
        chk_vec("step_stop_nodone", step_done, 0);

        // Step landing on load-use still completes
        do_reset();
        dbg_step = 1; tick(); dbg_step = 0;
        ex_m_mem_read = 1; ex_rt = 9; id_rt = 9;
        chk_ctl("step_lu_ctl", 5'b00011);
        tick(); clear_in();
        chk_vec("step_lu_done", step_done, 1);
        chk_vec("step_lu_cnt", stall_count, 1);

        // Saturation
        do_reset();
        dbg_run = 1; tick(); dbg_run = 0;
        ex_m_mem_read = 1; ex_rt = 3; id_rs = 3;
        repeat (65534) tick();
        chk_vec("sat_fffe", stall_count, 16'hFFFE);
        repeat (6) tick();
        chk_vec("sat_ffff", stall_count, 16'hFFFF);
        chk_ctl("sat_still_stall", 5'b00011);
        clear_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
